alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 104 ++++++++++
 tb/tb_alu_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with exact overflow detection (optional saturation via ALU_SAT_EN).
// Latency: 2 cycles from an accepted beat to a visible result; throughput 1 beat/cycle.
// Backpressure: out_valid && !out_ready stalls both stages; a stage-1 bubble can still be filled while stalled.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHL   = 3,
  parameter int SHR   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic [1:0]              select,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_put,
  output logic                    co,
  output logic                    ovf
);

  // Internal width is wide enough that no operation can wrap before the range check.
  localparam int IW = WIDTH + SHL + 2;

  localparam logic signed [IW-1:0] MAXV = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic                    s1_valid;
  logic signed [WIDTH-1:0] s1_a;
  logic signed [WIDTH-1:0] s1_b;
  logic [1:0]              s1_sel;

  logic                    stall;
  logic signed [IW-1:0]    a_x;
  logic signed [IW-1:0]    b_x;
  logic signed [IW-1:0]    diff;
  logic signed [IW-1:0]    exact;
  logic                    ovf_c;
  logic signed [WIDTH-1:0] res_c;

  // A full output register that is not being taken freezes the whole pipe.
  assign stall    = out_valid && !out_ready;
  assign in_ready = rst_n && (!stall || !s1_valid);

  // Exact result of the stage-1 operands, then range check and output mapping.
  always_comb begin
    a_x   = {{(IW-WIDTH){s1_a[WIDTH-1]}}, s1_a};
    b_x   = {{(IW-WIDTH){s1_b[WIDTH-1]}}, s1_b};
    diff  = (b_x <<< 1) + b_x - a_x;
    exact = '0;
    case (s1_sel)
      2'b11:   exact = (a_x <<< SHL) + (b_x >>> SHR);
      2'b10:   exact = b_x + (a_x <<< 1);
      2'b01:   exact = -b_x;
      default: exact = diff[IW-1] ? -diff : diff;
    endcase
    ovf_c = (exact > MAXV) || (exact < MINV);
`ifdef ALU_SAT_EN
    if (ovf_c) begin
      res_c = exact[IW-1] ? MINV[WIDTH-1:0] : MAXV[WIDTH-1:0];
    end else begin
      res_c = exact[WIDTH-1:0];
    end
`else
    res_c = exact[WIDTH-1:0];
`endif
  end

  // Stage 1: capture operands whenever the stage may advance (not stalled, or holding a bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_sel <= select;
      end
    end
  end

  // Stage 2: register result and flags; values are kept when no new beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_put   <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_put <= res_c;
        co      <= exact[WIDTH];
        ovf     <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with literal expectations plus a queue-based result model.
// Latency checked as 2 cycles from acceptance on idle pipe.
// Backpressure exercised by holding and toggling out_ready.
module tb_alu_pipe;
  localparam int W   = 8;
  localparam int SHL = 3;
  localparam int SHR = 2;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic [1:0]          select;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_put;
  logic                co;
  logic                ovf;

  alu_pipe #(.WIDTH(W), .SHL(SHL), .SHR(SHR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .select(select), .out_valid(out_valid), .out_ready(out_ready),
    .out_put(out_put), .co(co), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    logic         c;
    logic         v;
  } res_t;

  res_t         sb[$];
  logic [W-1:0] got[$];
  int           n_vec = 0;
  int           n_err = 0;

  // Spec-level model: exact integer arithmetic, then range check.
  function automatic res_t model(input logic [1:0] s, input int a, input int b);
    res_t    r;
    longint  e;
    longint  q;
    longint  d;
    longint  lmax;
    longint  lmin;
    lmax = (longint'(1) << (W-1)) - 1;
    lmin = -(longint'(1) << (W-1));
    d = longint'(1) << SHR;
    q = longint'(b) / d;
    if ((longint'(b) % d != 0) && (b < 0)) q = q - 1;
    case (s)
      2'b11:   e = longint'(a) * (longint'(1) << SHL) + q;
      2'b10:   e = longint'(b) + 2 * longint'(a);
      2'b01:   e = -longint'(b);
      default: begin
        e = 3 * longint'(b) - longint'(a);
        if (e < 0) e = -e;
      end
    endcase
    r.o = e[W-1:0];
    r.c = e[W];
    r.v = (e > lmax) || (e < lmin);
`ifdef ALU_SAT_EN
    if (r.v) r.o = (e > 0) ? lmax[W-1:0] : lmin[W-1:0];
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: record accepted beats, check every retired result in order.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra: unexpected result %0h", out_put);
          end else begin
            e = sb.pop_front();
            got.push_back(out_put);
            if (out_put !== e.o || co !== e.c || ovf !== e.v) begin
              n_err++;
              $display("FAIL sb_result: got out=%0h co=%0b ovf=%0b required out=%0h co=%0b ovf=%0b",
                       out_put, co, ovf, e.o, e.c, e.v);
            end
          end
        end
        if (in_valid && in_ready) sb.push_back(model(select, int'(A), int'(B)));
      end
    end
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [1:0] s, input int a, input int b);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    select   = s;
    A        = W'(a);
    B        = W'(b);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", guard);
    end
    in_valid = 1'b0;
  endtask

  // Single beat on an idle pipe: result must appear on the second edge.
  task automatic run_one(input string nm, input logic [1:0] s, input int a, input int b,
                         input logic [W-1:0] eo, input logic ec, input logic ev);
    send(s, a, b);
    @(posedge clk);
    #1;
    chk({nm, "_vld"}, W'(out_valid), W'(1));
    chk({nm, "_out"}, out_put, eo);
    chk({nm, "_co"}, W'(co), W'(ec));
    chk({nm, "_ovf"}, W'(ovf), W'(ev));
    @(posedge clk);
    #1;
  endtask

  int           ta[10] = '{-128, 127, -128, 127, 0, 5, -128, 127, -1, 15};
  int           tb[10] = '{-128, 127, -128, -1, 127, -1, -128, -128, 0, -3};
  logic [1:0]   ts[10] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};

  initial begin
    logic [15:0] pat;
    int          guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    select    = '0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_put", out_put, W'(0));
    chk("rst_co_ovf", W'({co, ovf}), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    #21;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    run_one("op11_basic", 2'b11, 1, 8, 8'd10, 1'b0, 1'b0);
`ifdef ALU_SAT_EN
    run_one("op10_300", 2'b10, 100, 100, 8'd127, 1'b1, 1'b1);
    run_one("op01_neg128", 2'b01, 0, -128, 8'd127, 1'b0, 1'b1);
    run_one("op00_509", 2'b00, -128, 127, 8'd127, 1'b1, 1'b1);
`else
    run_one("op10_300", 2'b10, 100, 100, 8'd44, 1'b1, 1'b1);
    run_one("op01_neg128", 2'b01, 0, -128, 8'h80, 1'b0, 1'b1);
    run_one("op00_509", 2'b00, -128, 127, 8'hFD, 1'b1, 1'b1);
`endif
    run_one("op00_small", 2'b00, 10, 2, 8'd4, 1'b0, 1'b0);

    // Backpressure: three beats offered while consumer stalls for four cycles.
    got.delete();
    out_ready = 1'b0;
    fork
      begin
        send(2'b10, 1, 0);
        send(2'b10, 2, 0);
        send(2'b10, 3, 0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
          chk("bp_in_ready", W'(in_ready), W'(0));
          chk("bp_out_valid", W'(out_valid), W'(1));
          chk("bp_out_hold", out_put, W'(2));
          if (i < 2) begin
            @(posedge clk);
            #1;
          end
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (got.size() < 3 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("bp_count", W'(got.size()), W'(3));
    if (got.size() >= 3) begin
      chk("bp_order0", got[0], W'(2));
      chk("bp_order1", got[1], W'(4));
      chk("bp_order2", got[2], W'(6));
    end

    // Back-to-back stream of corner operands under a toggling consumer.
    pat = 16'b1011_0010_1101_0110;
    fork
      begin
        for (int i = 0; i < 10; i++) send(ts[i], ta[i], tb[i]);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          out_ready = pat[i];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("stream_drained", W'(sb.size()), W'(0));

    // Reset with both stages full: outputs must clear without a clock edge.
    out_ready = 1'b0;
    send(2'b10, 5, 0);
    send(2'b10, 6, 0);
    chk("pre_rst_full", W'({out_valid, 1'b0}), W'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_out_put", out_put, W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_release_rdy", W'(in_ready), W'(1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_one("after_rst", 2'b10, 7, 1, 8'd15, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("final_sb_empty", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
